fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the 32-bit instruction ROM: owns the PC, drives its address/read enable, and
//  registers each word into a valid/ready slot feeding decode. Supports start, back-pressure,
//  redirect (jump/branch) and end-of-program halt. Sits between the ROM and the decode stage.
// PARAMETERS
//  ADDR_W        4   ROM address width; also the width of every PC port
//  DEPTH         15  populated ROM words; legal PCs are 0..DEPTH-1
//  DATA_W        32  instruction width
//  HALT_ON_ZERO  1   1: an all-zero word read while RUN is an end-of-program marker
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high
//  start           in   1       1-cycle pulse; begins fetching at PC 0
//  imem_addr       out  ADDR_W  ROM address; always equals pc
//  imem_read_en    out  1       ROM read enable
//  imem_instr      in   DATA_W  ROM data; combinational, valid in the same cycle
//  redirect_valid  in   1       load a new PC this cycle
//  redirect_pc     in   ADDR_W  target PC
//  out_valid       out  1       out_instr/out_pc hold a word for decode
//  out_ready       in   1       decode accepts the word
//  out_instr       out  DATA_W  fetched word
//  out_pc          out  ADDR_W  address the word came from
//  busy            out  1       state==RUN
//  done            out  1       state==HALT && !out_valid
//  error           out  1       sticky; set by an out-of-range redirect
//  fetch_count     out  ADDR_W+1  handshakes completed since start; saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, error=0, fetch_count=0.
//  Reset takes effect in any state, including mid-fetch, and flushes the slot.
//  FSM states: IDLE, RUN, HALT.
//   IDLE --start--> RUN: pc=0, count=0, error=0.
//   HALT --start--> RUN: same clears; out_valid=0 and any undrained word is discarded.
//   start is ignored in RUN.
//  imem_read_en = (state==RUN) && !redirect_valid && (!out_valid || out_ready).
//  load = imem_read_en, except no load when HALT_ON_ZERO && imem_instr==0.
//  On load: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
//   The word is visible 1 cycle after its address (latency 1).
//   Peak throughput is 1 word/cycle when out_ready is held high.
//  Handshake: out_valid && out_ready consumes the word. With no load that cycle,
//   out_valid<=0. While out_valid && !out_ready, out_instr/out_pc stay stable and pc holds.
//  fetch_count increments on every out_valid && out_ready cycle.
//  Redirect in RUN has highest priority.
//   Target < DEPTH: pc<=redirect_pc, out_valid<=0 (the pending word is flushed, not counted).
//   Target >= DEPTH: error<=1, state<=HALT, out_valid<=0.
//   Redirect is ignored in IDLE and HALT.
//  End of program:
//   A load at pc==DEPTH-1 -> state<=HALT; pc wraps to 0; the loaded word still drains.
//   A zero word with HALT_ON_ZERO=1 -> no load, state<=HALT, pc holds, the pending word drains.
//  Simultaneous consume + load: out_valid stays 1, new word replaces old, count+1.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2) and the ROM geometry
//   constants ADDR_W/DEPTH/DATA_W, also used by the ROM and decode.
//  Single module, no sub-modules. The ROM is instantiated beside it, not inside.
// TESTING (bench uses ROM image: 0:018D4820, 1:01CE5020, 2:01494022, 3..14: 0)
//  1. reset, start, out_ready=1 -> (out_pc,out_instr) = (0,018D4820), (1,01CE5020),
//     (2,01494022) on consecutive cycles; then HALT, done=1, fetch_count=3, pc=3.
//  2. out_ready=0 for 4 cycles after the first word -> out_instr holds 018D4820,
//     imem_read_en=0, pc=1; then release -> remaining 2 words arrive in order.
//  3. redirect_valid=1, redirect_pc=2 while holding word 0 -> flushed;
//     next word is (2,01494022); fetch_count ends at 1.
//  4. redirect_pc=15 -> error=1, HALT, out_valid=0; start then clears error and refetches
//     from 0.
//  5. HALT_ON_ZERO=0 -> all 15 words are delivered; after pc 14, HALT with pc=0 and
//     fetch_count=15.
//  6. reset asserted mid-RUN with out_valid=1 -> next cycle IDLE, out_valid=0, count=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//    Shared definitions for the instruction fetch path: the sequencer state
//    encoding and the instruction ROM geometry. The ROM model and the decode
//    stage use the same geometry constants.
//    Contents:
//       seqState_t  IDLE / RUN / HALT sequencer states
//       ADDR_W      ROM address width (also the PC width)
//       DEPTH       number of populated ROM words (legal PCs 0..DEPTH-1)
//       DATA_W      instruction width
package fetch_sequencer_pkg;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 15;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } seqState_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//    Bundles the two buses the fetch sequencer sits between: the ROM read
//    port and the valid/ready slot that feeds decode.
//    Signals:
//       imem_addr     ROM address (sequencer -> ROM)
//       imem_read_en  ROM read enable (sequencer -> ROM)
//       imem_instr    ROM data, combinational (ROM -> sequencer)
//       out_valid     slot holds a word (sequencer -> decode)
//       out_ready     decode accepts the word (decode -> sequencer)
//       out_instr     fetched word (sequencer -> decode)
//       out_pc        address the word came from (sequencer -> decode)
//    Modports:
//       master  sequencer side
//       slave   ROM/decode side
interface fetch_sequencer_if #(
   parameter int ADDR_W = fetch_sequencer_pkg::ADDR_W,
   parameter int DATA_W = fetch_sequencer_pkg::DATA_W
);

   logic [ADDR_W-1:0] imem_addr;
   logic              imem_read_en;
   logic [DATA_W-1:0] imem_instr;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;

   modport master (
      output imem_addr, imem_read_en, out_valid, out_instr, out_pc,
      input  imem_instr, out_ready
   );

   modport slave (
      input  imem_addr, imem_read_en, out_valid, out_instr, out_pc,
      output imem_instr, out_ready
   );

endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//    Owns the program counter, reads the instruction ROM and registers each
//    word into a single valid/ready slot for decode. Handles start, decode
//    back-pressure, redirects (jump/branch) and end-of-program halt.
//    Ports:
//       clk             rising-edge clock
//       reset           synchronous, active-high; flushes the slot
//       start           1-cycle pulse, begins fetching at PC 0 (ignored in RUN)
//       redirect_valid  load redirect_pc as the new PC this cycle (RUN only)
//       redirect_pc     redirect target
//       bus             ROM read port + decode slot (master side)
//       busy            sequencer is in RUN
//       done            sequencer is in HALT and the slot has drained
//       error           sticky, set by an out-of-range redirect
//       fetch_count     completed handshakes since start, saturating
module fetch_sequencer #(
   parameter int ADDR_W       = fetch_sequencer_pkg::ADDR_W,
   parameter int DEPTH        = fetch_sequencer_pkg::DEPTH,
   parameter int DATA_W       = fetch_sequencer_pkg::DATA_W,
   parameter bit HALT_ON_ZERO = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   fetch_sequencer_if.master        bus,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [ADDR_W:0]          fetch_count
);

   import fetch_sequencer_pkg::*;

   localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DepthW = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);

   seqState_t         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              outValid_q, outValid_d;
   logic [DATA_W-1:0] outInstr_q, outInstr_d;
   logic [ADDR_W-1:0] outPc_q, outPc_d;
   logic              error_q, error_d;
   logic [ADDR_W:0]   fetchCount_q, fetchCount_d;

   logic readEn;
   logic zeroWord;
   logic load;
   logic consume;

   // The ROM is read only when the slot can take a word this cycle: either
   // it is empty or decode is draining it. A redirect suppresses the read
   // because the address about to be presented is stale. An all-zero word
   // is the end-of-program marker and is never loaded into the slot.
   always_comb begin
      readEn   = (state_q == RUN) && !redirect_valid && (!outValid_q || bus.out_ready);
      zeroWord = HALT_ON_ZERO && (bus.imem_instr == '0);
      load     = readEn && !zeroWord;
      consume  = outValid_q && bus.out_ready;
   end

   // Next-state logic. Redirect outranks everything in RUN and flushes the
   // pending word without counting it. In HALT the slot keeps draining so the
   // last word fetched still reaches decode. A start from IDLE or HALT
   // restarts at PC 0 and discards anything left in the slot.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      outValid_d   = outValid_q;
      outInstr_d   = outInstr_q;
      outPc_d      = outPc_q;
      error_d      = error_q;
      fetchCount_d = fetchCount_q;

      if (consume && (fetchCount_q != '1)) begin
         fetchCount_d = fetchCount_q + 1'b1;
      end

      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d      = RUN;
               pc_d         = '0;
               fetchCount_d = '0;
               error_d      = 1'b0;
               outValid_d   = 1'b0;
            end else if (consume) begin
               outValid_d = 1'b0;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               fetchCount_d = fetchCount_q;
               outValid_d   = 1'b0;
               if ({1'b0, redirect_pc} < DepthW) begin
                  pc_d = redirect_pc;
               end else begin
                  error_d = 1'b1;
                  state_d = HALT;
               end
            end else begin
               if (load) begin
                  outInstr_d = bus.imem_instr;
                  outPc_d    = pc_q;
                  outValid_d = 1'b1;
                  if (pc_q == LastPc) begin
                     pc_d    = '0;
                     state_d = HALT;
                  end else begin
                     pc_d = pc_q + PcOne;
                  end
               end else if (consume) begin
                  outValid_d = 1'b0;
               end
               if (readEn && zeroWord) begin
                  state_d = HALT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset flushes the slot in any state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         outValid_q   <= 1'b0;
         outInstr_q   <= '0;
         outPc_q      <= '0;
         error_q      <= 1'b0;
         fetchCount_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         outValid_q   <= outValid_d;
         outInstr_q   <= outInstr_d;
         outPc_q      <= outPc_d;
         error_q      <= error_d;
         fetchCount_q <= fetchCount_d;
      end
   end

   // Output mapping; the ROM address always tracks the PC.
   always_comb begin
      bus.imem_addr    = pc_q;
      bus.imem_read_en = readEn;
      bus.out_valid    = outValid_q;
      bus.out_instr    = outInstr_q;
      bus.out_pc       = outPc_q;
      busy             = (state_q == RUN);
      done             = (state_q == HALT) && !outValid_q;
      error            = error_q;
      fetch_count      = fetchCount_q;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//    Directed bench for fetch_sequencer. dut0 uses the end-of-program zero
//    marker, dut1 has it disabled and walks the whole ROM. Both share one ROM
//    image: three real words followed by zeros.
module tb_fetch_sequencer;

   localparam int AW = fetch_sequencer_pkg::ADDR_W;
   localparam int DW = fetch_sequencer_pkg::DATA_W;

   localparam logic [31:0] W0 = 32'h018D4820;
   localparam logic [31:0] W1 = 32'h01CE5020;
   localparam logic [31:0] W2 = 32'h01494022;

   logic clk = 1'b0;

   logic          reset0 = 1'b1, start0 = 1'b0, redirValid0 = 1'b0, outReady0 = 1'b0;
   logic [AW-1:0] redirPc0 = '0;
   logic          busy0, done0, error0;
   logic [AW:0]   count0;

   logic          reset1 = 1'b1, start1 = 1'b0, outReady1 = 1'b0;
   logic          busy1, done1, error1;
   logic [AW:0]   count1;

   logic [DW-1:0] romImage [0:15];

   int checkCount = 0;
   int errorCount = 0;

   fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifc0 ();
   fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifc1 ();

   fetch_sequencer #(.HALT_ON_ZERO(1'b1)) dut0 (
      .clk            (clk),
      .reset          (reset0),
      .start          (start0),
      .redirect_valid (redirValid0),
      .redirect_pc    (redirPc0),
      .bus            (ifc0.master),
      .busy           (busy0),
      .done           (done0),
      .error          (error0),
      .fetch_count    (count0)
   );

   fetch_sequencer #(.HALT_ON_ZERO(1'b0)) dut1 (
      .clk            (clk),
      .reset          (reset1),
      .start          (start1),
      .redirect_valid (1'b0),
      .redirect_pc    ('0),
      .bus            (ifc1.master),
      .busy           (busy1),
      .done           (done1),
      .error          (error1),
      .fetch_count    (count1)
   );

   // Combinational ROM models, one read port per sequencer.
   assign ifc0.imem_instr = romImage[ifc0.imem_addr];
   assign ifc0.out_ready  = outReady0;
   assign ifc1.imem_instr = romImage[ifc1.imem_addr];
   assign ifc1.out_ready  = outReady1;

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Expected ROM contents for the full walk on dut1.
   function automatic logic [31:0] expectedWord(input int k);
      case (k)
         0:       return W0;
         1:       return W1;
         2:       return W2;
         default: return 32'h0;
      endcase
   endfunction

   // Directed test sequence.
   initial begin
      for (int i = 0; i < 16; i++) romImage[i] = '0;
      romImage[0] = W0;
      romImage[1] = W1;
      romImage[2] = W2;

      // Reset state.
      applyStimulus();
      checkOutput("rst_busy", 32'(busy0), 32'd0);
      checkOutput("rst_done", 32'(done0), 32'd0);
      checkOutput("rst_valid", 32'(ifc0.out_valid), 32'd0);
      checkOutput("rst_instr", ifc0.out_instr, 32'h0);
      checkOutput("rst_outpc", 32'(ifc0.out_pc), 32'd0);
      checkOutput("rst_error", 32'(error0), 32'd0);
      checkOutput("rst_count", 32'(count0), 32'd0);
      checkOutput("rst_pc", 32'(ifc0.imem_addr), 32'd0);
      reset0 = 1'b0;

      // Test 1: full-rate fetch of the three-word program.
      outReady0 = 1'b1;
      start0 = 1'b1;
      applyStimulus();
      start0 = 1'b0;
      checkOutput("t1_busy", 32'(busy0), 32'd1);
      checkOutput("t1_rden", 32'(ifc0.imem_read_en), 32'd1);
      applyStimulus();
      checkOutput("t1_w0_valid", 32'(ifc0.out_valid), 32'd1);
      checkOutput("t1_w0_pc", 32'(ifc0.out_pc), 32'd0);
      checkOutput("t1_w0_instr", ifc0.out_instr, W0);
      applyStimulus();
      checkOutput("t1_w1_pc", 32'(ifc0.out_pc), 32'd1);
      checkOutput("t1_w1_instr", ifc0.out_instr, W1);
      applyStimulus();
      checkOutput("t1_w2_pc", 32'(ifc0.out_pc), 32'd2);
      checkOutput("t1_w2_instr", ifc0.out_instr, W2);
      applyStimulus();
      checkOutput("t1_done", 32'(done0), 32'd1);
      checkOutput("t1_busy_end", 32'(busy0), 32'd0);
      checkOutput("t1_count", 32'(count0), 32'd3);
      checkOutput("t1_pc", 32'(ifc0.imem_addr), 32'd3);

      // Test 2: back-pressure after the first word.
      start0 = 1'b1;
      applyStimulus();
      start0 = 1'b0;
      checkOutput("t2_count_clr", 32'(count0), 32'd0);
      outReady0 = 1'b0;
      applyStimulus();
      for (int i = 0; i < 4; i++) begin
         checkOutput("t2_hold_valid", 32'(ifc0.out_valid), 32'd1);
         checkOutput("t2_hold_instr", ifc0.out_instr, W0);
         checkOutput("t2_hold_rden", 32'(ifc0.imem_read_en), 32'd0);
         checkOutput("t2_hold_pc", 32'(ifc0.imem_addr), 32'd1);
         applyStimulus();
      end
      outReady0 = 1'b1;
      #1;
      checkOutput("t2_rel_rden", 32'(ifc0.imem_read_en), 32'd1);
      applyStimulus();
      checkOutput("t2_w1_pc", 32'(ifc0.out_pc), 32'd1);
      checkOutput("t2_w1_instr", ifc0.out_instr, W1);
      applyStimulus();
      checkOutput("t2_w2_pc", 32'(ifc0.out_pc), 32'd2);
      checkOutput("t2_w2_instr", ifc0.out_instr, W2);
      applyStimulus();
      checkOutput("t2_count", 32'(count0), 32'd3);
      checkOutput("t2_done", 32'(done0), 32'd1);

      // Test 3: redirect to PC 2 while word 0 is held.
      start0 = 1'b1;
      applyStimulus();
      start0 = 1'b0;
      outReady0 = 1'b0;
      applyStimulus();
      redirValid0 = 1'b1;
      redirPc0 = 4'd2;
      #1;
      checkOutput("t3_redir_rden", 32'(ifc0.imem_read_en), 32'd0);
      applyStimulus();
      redirValid0 = 1'b0;
      checkOutput("t3_flush_valid", 32'(ifc0.out_valid), 32'd0);
      checkOutput("t3_new_pc", 32'(ifc0.imem_addr), 32'd2);
      outReady0 = 1'b1;
      applyStimulus();
      checkOutput("t3_w2_pc", 32'(ifc0.out_pc), 32'd2);
      checkOutput("t3_w2_instr", ifc0.out_instr, W2);
      applyStimulus();
      checkOutput("t3_count", 32'(count0), 32'd1);
      checkOutput("t3_done", 32'(done0), 32'd1);

      // Test 4: out-of-range redirect, then restart clears the error.
      start0 = 1'b1;
      applyStimulus();
      start0 = 1'b0;
      applyStimulus();
      redirValid0 = 1'b1;
      redirPc0 = 4'd15;
      applyStimulus();
      redirValid0 = 1'b0;
      checkOutput("t4_error", 32'(error0), 32'd1);
      checkOutput("t4_busy", 32'(busy0), 32'd0);
      checkOutput("t4_valid", 32'(ifc0.out_valid), 32'd0);
      checkOutput("t4_done", 32'(done0), 32'd1);
      checkOutput("t4_count", 32'(count0), 32'd0);
      start0 = 1'b1;
      applyStimulus();
      start0 = 1'b0;
      checkOutput("t4_err_clr", 32'(error0), 32'd0);
      checkOutput("t4_restart_pc", 32'(ifc0.imem_addr), 32'd0);
      checkOutput("t4_restart_busy", 32'(busy0), 32'd1);
      applyStimulus();
      checkOutput("t4_w0_pc", 32'(ifc0.out_pc), 32'd0);
      checkOutput("t4_w0_instr", ifc0.out_instr, W0);

      // Test 6: reset mid-RUN with a word in the slot.
      applyStimulus();
      checkOutput("t6_pre_count", 32'(count0), 32'd1);
      checkOutput("t6_pre_valid", 32'(ifc0.out_valid), 32'd1);
      reset0 = 1'b1;
      applyStimulus();
      reset0 = 1'b0;
      checkOutput("t6_busy", 32'(busy0), 32'd0);
      checkOutput("t6_done", 32'(done0), 32'd0);
      checkOutput("t6_valid", 32'(ifc0.out_valid), 32'd0);
      checkOutput("t6_count", 32'(count0), 32'd0);
      checkOutput("t6_outpc", 32'(ifc0.out_pc), 32'd0);

      // Test 5: zero marker disabled, all fifteen words delivered.
      reset1 = 1'b0;
      outReady1 = 1'b1;
      start1 = 1'b1;
      applyStimulus();
      start1 = 1'b0;
      for (int k = 0; k < 15; k++) begin
         applyStimulus();
         checkOutput("t5_valid", 32'(ifc1.out_valid), 32'd1);
         checkOutput("t5_pc", 32'(ifc1.out_pc), 32'(k));
         checkOutput("t5_instr", ifc1.out_instr, expectedWord(k));
      end
      checkOutput("t5_wrap_pc", 32'(ifc1.imem_addr), 32'd0);
      checkOutput("t5_halt", 32'(busy1), 32'd0);
      checkOutput("t5_rden", 32'(ifc1.imem_read_en), 32'd0);
      applyStimulus();
      checkOutput("t5_count", 32'(count1), 32'd15);
      checkOutput("t5_done", 32'(done1), 32'd1);
      checkOutput("t5_error", 32'(error1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
